// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFOv2 stream sequencer.
//   ctrl_state_t   : sequencer state encoding
//   CTRL_MAX_nDATA : largest transfer length per job
//   CTRL_WIDTH     : default data word width
package fifo_ctrl_pkg;

  localparam int unsigned CTRL_WIDTH     = 16;
  localparam int unsigned CTRL_MAX_nDATA = 1126;
  localparam int unsigned CTRL_CFG_W     = $clog2(CTRL_MAX_nDATA);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/fifo_xfer_cnt.sv
// Saturating transfer counter: counts accepted transfers up to a limit.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : count one transfer (ignored once the limit is reached)
//   clr       : zero the count (wins over inc)
//   limit     : job length
//   cnt       : current count
//   at_limit  : cnt has reached limit
module fifo_xfer_cnt #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  assign at_limit = (cnt >= limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fifo_stream_ctrl.sv
// Per-job sequencer for one FIFOv2: clears the FIFO, programs the length and
// moves exactly n words producer -> FIFO -> consumer, then pulses done.
//   clk, rst                  : clock, synchronous active-high reset
//   start, abort, cfg_ndata   : job control from the layer scheduler
//   in_valid/in_ready/in_data : producer handshake
//   out_valid/out_ready/out_data : consumer handshake
//   fifo_*                    : FIFOv2 controls and status
//   busy, done                : job status
module fifo_stream_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH            = CTRL_WIDTH,
  parameter int unsigned MAX_nDATA        = CTRL_MAX_nDATA,
  parameter int unsigned WIDTH_CONFIGBITS = $clog2(MAX_nDATA)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WIDTH_CONFIGBITS-1:0] cfg_ndata,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        fifo_we,
  output logic                        fifo_re,
  output logic                        fifo_clear,
  output logic [WIDTH-1:0]            fifo_data_in,
  output logic [WIDTH_CONFIGBITS-1:0] fifo_config_bits,
  input  logic                        fifo_full,
  input  logic                        fifo_empty,
  input  logic [WIDTH-1:0]            fifo_data_out,
  output logic                        busy,
  output logic                        done
);

  localparam logic [WIDTH_CONFIGBITS-1:0] LEN_MAX = WIDTH_CONFIGBITS'(MAX_nDATA);

  ctrl_state_t                 state, state_nxt;
  logic [WIDTH_CONFIGBITS-1:0] n_len, wr_cnt, rd_cnt, cfg_len;
  logic                        wr_at_lim, rd_at_lim, abort_pending;
  logic                        start_acc, abort_hit, run_ok, cnt_clr, rd_last;
  logic                        unused_wr_cnt;

  // Write count has no consumer here; the at_limit flag gates the producer.
  assign unused_wr_cnt = ^wr_cnt;

  assign cfg_len      = (cfg_ndata > LEN_MAX) ? LEN_MAX : cfg_ndata;
  assign start_acc    = (state == IDLE) && start && !abort;
  assign abort_hit    = abort && (state != IDLE);
  assign run_ok       = (state == RUN) && !abort;
  assign cnt_clr      = start_acc || abort_hit;

  assign fifo_data_in     = in_data;
  assign out_data         = fifo_data_out;
  assign fifo_config_bits = n_len;

  fifo_xfer_cnt #(.W(WIDTH_CONFIGBITS)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (fifo_we),
    .clr      (cnt_clr),
    .limit    (n_len),
    .cnt      (wr_cnt),
    .at_limit (wr_at_lim)
  );

  fifo_xfer_cnt #(.W(WIDTH_CONFIGBITS)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (fifo_re),
    .clr      (cnt_clr),
    .limit    (n_len),
    .cnt      (rd_cnt),
    .at_limit (rd_at_lim)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/FIFO controls
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    fifo_we    = 1'b0;
    fifo_re    = 1'b0;
    rd_last    = 1'b0;
    fifo_clear = (state == CLEAR);
    busy       = (state != IDLE);
    done       = (state == DONE);

    in_ready = run_ok && !fifo_full && !wr_at_lim;
    fifo_we  = in_valid && in_ready;
    // A read may only be issued when the output register is free or draining.
    fifo_re  = run_ok && !fifo_empty && !rd_at_lim && (!out_valid || out_ready);
    rd_last  = fifo_re && (rd_cnt == (n_len - WIDTH_CONFIGBITS'(1)));

    unique case (state)
      IDLE:    if (start_acc) state_nxt = (cfg_ndata == '0) ? DONE : CLEAR;
      CLEAR:   state_nxt = abort_pending ? IDLE : RUN;
      RUN:     if (rd_last) state_nxt = FLUSH;
      FLUSH:   if (out_valid && out_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (abort_hit) state_nxt = CLEAR;
  end

  // Job length, abort tracking and output-valid register
  always_ff @(posedge clk) begin
    if (rst) begin
      n_len         <= '0;
      abort_pending <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      if (start_acc && (cfg_ndata != '0)) n_len <= cfg_len;

      if (abort_hit)           abort_pending <= 1'b1;
      else if (state == CLEAR) abort_pending <= 1'b0;

      if (abort_hit)      out_valid <= 1'b0;
      else if (fifo_re)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_stream_ctrl.md
# fifo_stream_ctrl

Sequencer for one FIFOv2 buffer in the Arthas datapath. Per job it clears the FIFO, programs the transfer length, and moves exactly `nData` words from a valid/ready producer through the FIFO to a valid/ready consumer. It raises `done` once the last word has been accepted downstream. It sits between the layer scheduler, which issues `start`, and the FIFOv2 instance, whose `we`/`re`/`clear`/`config_bits` it drives exclusively.

## Interface
- `WIDTH`, 16, data word width (matches FIFOv2)
- `MAX_nDATA`, 1126, largest transfer length per job
- `WIDTH_CONFIGBITS`, `$clog2(MAX_nDATA)`, width of length fields
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job request; sampled only in IDLE
- `abort`  in  1  kill current job; priority over everything except `rst`
- `cfg_ndata`  in  WIDTH_CONFIGBITS  job length, latched on accepted `start`
- `in_valid` / `in_ready`  in / out  1  producer handshake
- `in_data`  in  WIDTH  producer word
- `out_valid` / `out_ready`  out / in  1  consumer handshake
- `out_data`  out  WIDTH  consumer word (= `fifo_data_out`)
- `fifo_we`, `fifo_re`, `fifo_clear`  out  1  FIFOv2 controls
- `fifo_data_in`  out  WIDTH  = `in_data`
- `fifo_config_bits`  out  WIDTH_CONFIGBITS  latched `cfg_ndata`
- `fifo_full`, `fifo_empty`  in  1  FIFOv2 status
- `fifo_data_out`  in  WIDTH  FIFOv2 read data: valid the cycle after `fifo_re`, held while `fifo_re` is low
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at job completion

## Operation
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE: `start` with `cfg_ndata` != 0 latches the length, zeroes `wr_cnt`/`rd_cnt`, and moves to CLEAR. `start` with `cfg_ndata` == 0 moves directly to DONE.
- CLEAR: `fifo_clear` = 1 for exactly this cycle, then RUN.
- RUN:
  - `in_ready = !fifo_full && wr_cnt < n`; `fifo_we = in_valid && in_ready`; `wr_cnt++` on each write.
  - `fifo_re = !fifo_empty && rd_cnt < n && (!out_valid || out_ready)`; `rd_cnt++` on each read.
  - Write and read in the same cycle are allowed.
  - On the cycle `fifo_re` issues the read that makes `rd_cnt == n`, go to FLUSH.
- `out_valid` register: set the cycle after `fifo_re`. Cleared when `out_ready && out_valid` and no new `fifo_re` in that cycle.
- FLUSH: wait until `out_valid && out_ready`, then DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `abort` in any non-IDLE state:
  - Next cycle enters CLEAR with `out_valid` = 0 and counters zeroed.
  - After CLEAR, returns to IDLE instead of RUN, tracked by an `abort_pending` flag.
  - No `done` pulse is produced.
- `start` while `busy` is ignored. `cfg_ndata` changes after the accept have no effect.
- Counters are WIDTH_CONFIGBITS bits wide. They never exceed `n`, so no wrap is possible. `cfg_ndata > MAX_nDATA` is clamped to MAX_nDATA.
- `fifo_re` never issues when `fifo_empty`; `fifo_we` never issues when `fifo_full`.

## Timing
- Reset values:
  - state = IDLE; `wr_cnt` = `rd_cnt` = 0; `fifo_config_bits` = 0.
  - `busy`, `done`, `out_valid`, `in_ready`, `fifo_we`, `fifo_re`, `fifo_clear` all 0.
  - `rst` mid-job discards everything, with no clear pulse and no `done`.
- Job sequence: `start` at cycle 0 → CLEAR at 1 → RUN at 2. The first write can occur at cycle 2; the first read can occur at cycle 3 at the earliest.
- Read-to-output latency: 1 cycle. With `out_ready` held high, throughput is 1 word/cycle.
- `done` asserts exactly 1 cycle after the final consumer handshake. `busy` falls in the cycle after `done`.
- All outputs are registered or derived combinationally from registered state plus FIFO status/handshake inputs. There is no combinational path from `out_ready` to `in_ready`.

## Structure
- Package `fifo_ctrl_pkg`:
  - `ctrl_state_t` enum (IDLE, CLEAR, RUN, FLUSH, DONE).
  - Constant `CTRL_MAX_nDATA` = 1126.
- Sub-module `fifo_xfer_cnt`:
  - Saturating up-counter with `inc`, `clr`, `limit` inputs and `cnt`, `at_limit` outputs.
  - Instantiated twice, for write and read.
- The FSM and the `out_valid` register live in the top.

## Test plan
- Basic: `cfg_ndata` = 5, producer and consumer always ready, data 1..5 → one `fifo_clear` pulse, output sequence 1,2,3,4,5, `done` at cycle 9, `in_ready` low after the fifth write.
- Backpressure: `cfg_ndata` = 8, `out_ready` toggling 1,0,0,1… → `out_data` stable while stalled, no duplicate or lost words, `done` after the eighth handshake.
- Full FIFO: FIFO depth 128, `cfg_ndata` = 200, `out_ready` = 0 for 150 cycles → `in_ready` drops exactly when `fifo_full`, and all 200 words are delivered in order after release.
- Zero length: `start` with `cfg_ndata` = 0 → no `fifo_clear`, `done` pulses at cycle 1.
- Abort: `abort` after 3 of 10 words → next cycle `fifo_clear` = 1, `out_valid` = 0, IDLE the cycle after, no `done`. A new job of 4 words then completes cleanly.
- Reset mid-job: `rst` during RUN → all outputs 0 the next cycle, and `start` is accepted immediately afterwards.
